// File: rtl/channel_burst_arbiter.sv
// channel_burst_arbiter
// Holds a per-channel {priority, remaining beats} table that the arbitration
// FSM loads through the sample interface. An arbitrate pulse drains the whole
// table as AXI write bursts, one outstanding burst at a time. Before every
// burst the arbiter re-picks the winner: highest priority first, with equal
// priorities rotating round-robin after the last served channel.
module channel_burst_arbiter #(
  parameter int NUM_CHANNELS  = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int PRIO_WIDTH    = 4,
  parameter int SIZE_WIDTH    = 32
) (
  input  logic                  AXI_aclk,
  input  logic                  AXI_areset,
  input  logic                  arbSample,
  input  logic [5:0]            arbCurrentChannelSample,
  input  logic [PRIO_WIDTH-1:0] arbChannelPriority,
  input  logic [SIZE_WIDTH-1:0] arbChannelTransferSize,
  input  logic                  arbitrate,
  output logic                  arbWriteTransactionsDone,
  output logic                  arbBusy,
  output logic                  arbIdError,
  output logic                  burst_valid,
  input  logic                  burst_ready,
  output logic [5:0]            burst_channel,
  output logic [7:0]            burst_len,
  output logic                  burst_last,
  input  logic                  burst_done
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SELECT    = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  // FSM and control registers
  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] win_q;
  logic [8:0]       beats_q;
  logic             done_q;
  logic             id_error_q;

  // Registered burst request towards the write burst engine
  logic             burst_valid_q;
  logic [5:0]       burst_channel_q;
  logic [7:0]       burst_len_q;
  logic             burst_last_q;

  // Channel table
  logic [NUM_CHANNELS-1:0] valid_q;
  logic [PRIO_WIDTH-1:0]   prio_q [NUM_CHANNELS];
  logic [SIZE_WIDTH-1:0]   rem_q  [NUM_CHANNELS];

  // Decoded sample and handshake controls
  logic             id_ok;
  logic             sample_ok;
  logic [IDX_W-1:0] sample_idx;
  logic             size_zero;
  logic             handshake;

  // Arbitration result and burst sizing of the latched winner
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_id;
  logic [PRIO_WIDTH-1:0] sel_prio;
  logic [SIZE_WIDTH-1:0] rem_sel;
  logic [8:0]            beats_d;
  logic                  last_d;

  // All six ID bits take part in the range check so that e.g. ID 40 never
  // aliases onto channel 8.
  assign id_ok      = {1'b0, arbCurrentChannelSample} < 7'(NUM_CHANNELS);
  assign sample_ok  = arbSample && id_ok;
  assign sample_idx = IDX_W'(arbCurrentChannelSample);
  assign size_zero  = (arbChannelTransferSize == '0);
  assign handshake  = (state_q == S_ISSUE) && burst_valid_q && burst_ready;

  // Priority search over valid entries, scanning upward from rr_ptr+1 so the
  // first entry of the top priority met in scan order wins a tie.
  always_comb begin
    int pos;
    logic [IDX_W-1:0] idx;
    // NOTE: every variable written here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    sel_found = 1'b0;
    sel_id    = '0;
    sel_prio  = '0;
    pos       = 0;
    idx       = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NUM_CHANNELS) pos = pos - NUM_CHANNELS;
      idx = IDX_W'(pos);
      if (valid_q[idx] && (!sel_found || (prio_q[idx] > sel_prio))) begin
        sel_found = 1'b1;
        sel_id    = idx;
        sel_prio  = prio_q[idx];
      end
    end
  end

  // Beat count and last flag for the next burst of the latched winner
  always_comb begin
    rem_sel = rem_q[win_q];
    if (rem_sel > SIZE_WIDTH'(MAX_BURST_LEN)) begin
      beats_d = 9'(MAX_BURST_LEN);
      last_d  = 1'b0;
    end else begin
      beats_d = rem_sel[8:0];
      last_d  = 1'b1;
    end
  end

  // Next-state logic of the arbitration FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (arbitrate) state_d = S_SELECT;
      S_SELECT:    state_d = sel_found ? S_ISSUE : S_DONE;
      S_ISSUE:     if (handshake) state_d = S_WAIT_RESP;
      S_WAIT_RESP: if (burst_done) state_d = S_SELECT;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM state, winner latch, burst request registers and status flags
  always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
    if (AXI_areset) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      win_q           <= '0;
      beats_q         <= '0;
      done_q          <= 1'b0;
      id_error_q      <= 1'b0;
      burst_valid_q   <= 1'b0;
      burst_channel_q <= '0;
      burst_len_q     <= '0;
      burst_last_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
      if (arbSample && !id_ok) id_error_q <= 1'b1;
      if ((state_q == S_SELECT) && sel_found) win_q <= sel_id;
      // First ISSUE cycle: build the request from the winner's current entry.
      if ((state_q == S_ISSUE) && !burst_valid_q) begin
        burst_valid_q   <= 1'b1;
        burst_channel_q <= 6'(win_q);
        burst_len_q     <= 8'(beats_d - 9'd1);
        burst_last_q    <= last_d;
        beats_q         <= beats_d;
      end
      if (handshake) begin
        burst_valid_q <= 1'b0;
        rr_ptr_q      <= win_q;
      end
    end
  end

  // Table valid bits: a sample to an entry overrides a same-cycle decrement
  always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
    if (AXI_areset) begin
      valid_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (sample_ok && (sample_idx == IDX_W'(c))) begin
          valid_q[c] <= !size_zero;
        end else if (handshake && (win_q == IDX_W'(c)) &&
                     (rem_q[c] <= SIZE_WIDTH'(beats_q))) begin
          valid_q[c] <= 1'b0;
        end
      end
    end
  end

  // Table payload: priority and remaining beats per channel
  // NOTE: payload fields carry no reset; they are only read while the
  // matching valid bit is set, and that bit is cleared by reset.
  always_ff @(posedge AXI_aclk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (sample_ok && (sample_idx == IDX_W'(c))) begin
        if (!size_zero) begin
          prio_q[c] <= arbChannelPriority;
          rem_q[c]  <= arbChannelTransferSize;
        end
      end else if (handshake && (win_q == IDX_W'(c)) && valid_q[c]) begin
        // Saturating subtract: a sample between load and handshake may
        // have shrunk the entry below the beats already promised.
        if (rem_q[c] <= SIZE_WIDTH'(beats_q)) rem_q[c] <= '0;
        else                                  rem_q[c] <= rem_q[c] - SIZE_WIDTH'(beats_q);
      end
    end
  end

  assign arbWriteTransactionsDone = done_q;
  assign arbBusy                  = (state_q != S_IDLE);
  assign arbIdError               = id_error_q;
  assign burst_valid              = burst_valid_q;
  assign burst_channel            = burst_channel_q;
  assign burst_len                = burst_len_q;
  assign burst_last               = burst_last_q;

endmodule

// File: tb/tb_channel_burst_arbiter.sv
// Self-checking bench for channel_burst_arbiter: directed scenarios plus
// randomized rounds, all compared against a table-level reference model.
module tb_channel_burst_arbiter;

  localparam int NCH  = 32;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arbSample = 1'b0;
  logic [5:0]  arbCurrentChannelSample = '0;
  logic [3:0]  arbChannelPriority = '0;
  logic [31:0] arbChannelTransferSize = '0;
  logic        arbitrate = 1'b0;
  logic        arbWriteTransactionsDone;
  logic        arbBusy;
  logic        arbIdError;
  logic        burst_valid;
  logic        burst_ready = 1'b0;
  logic [5:0]  burst_channel;
  logic [7:0]  burst_len;
  logic        burst_last;
  logic        burst_done = 1'b0;

  channel_burst_arbiter #(
    .NUM_CHANNELS(NCH), .MAX_BURST_LEN(MAXB), .PRIO_WIDTH(4), .SIZE_WIDTH(32)
  ) dut (
    .AXI_aclk(clk),
    .AXI_areset(rst),
    .arbSample(arbSample),
    .arbCurrentChannelSample(arbCurrentChannelSample),
    .arbChannelPriority(arbChannelPriority),
    .arbChannelTransferSize(arbChannelTransferSize),
    .arbitrate(arbitrate),
    .arbWriteTransactionsDone(arbWriteTransactionsDone),
    .arbBusy(arbBusy),
    .arbIdError(arbIdError),
    .burst_valid(burst_valid),
    .burst_ready(burst_ready),
    .burst_channel(burst_channel),
    .burst_len(burst_len),
    .burst_last(burst_last),
    .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: the channel table as plain arrays
  bit m_valid [NCH];
  int m_prio  [NCH];
  int m_rem   [NCH];
  int m_rr;
  bit m_err;
  int grants[$];

  // Scenario knobs for run_arb (-1 means random)
  int force_bp   = 0;
  int done_dly   = 3;
  bit hi_inject  = 1'b0;
  bit arb_inject = 1'b0;
  bit rand_mid   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_valid[i] = 1'b0;
      m_prio[i]  = 0;
      m_rem[i]   = 0;
    end
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  // Highest priority among valid entries; ties go to the nearest ID above rr.
  function automatic int model_winner();
    int best = -1;
    for (int k = 1; k <= NCH; k++) begin
      int id = (m_rr + k) % NCH;
      if (m_valid[id] && (best < 0 || m_prio[id] > m_prio[best])) best = id;
    end
    return best;
  endfunction

  task automatic do_sample(input int id, input int p, input int s);
    arbSample               = 1'b1;
    arbCurrentChannelSample = 6'(id);
    arbChannelPriority      = 4'(p);
    arbChannelTransferSize  = 32'(s);
    tick();
    arbSample = 1'b0;
    if (id >= NCH) m_err = 1'b1;
    else if (s == 0) m_valid[id] = 1'b0;
    else begin
      m_valid[id] = 1'b1;
      m_prio[id]  = p;
      m_rem[id]   = s;
    end
    check("id_error", 32'(arbIdError), 32'(m_err));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(arbBusy), 0);
    check({tag, "_valid"}, 32'(burst_valid), 0);
    check({tag, "_chan"},  32'(burst_channel), 0);
    check({tag, "_len"},   32'(burst_len), 0);
    check({tag, "_last"},  32'(burst_last), 0);
    check({tag, "_done"},  32'(arbWriteTransactionsDone), 0);
    check({tag, "_iderr"}, 32'(arbIdError), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic check_burst(input int w);
    int b = (m_rem[w] > MAXB) ? MAXB : m_rem[w];
    check("burst_valid",   32'(burst_valid), 1);
    check("burst_channel", 32'(burst_channel), 32'(w));
    check("burst_len",     32'(burst_len), 32'(b - 1));
    check("burst_last",    32'(burst_last), 32'(m_rem[w] <= MAXB));
  endtask

  // One arbitrate pulse, acting as burst engine until the done pulse.
  task automatic run_arb(output int nb);
    int w, bp, dly;
    bit finished = 1'b0;
    nb = 0;
    arbitrate = 1'b1;
    tick();
    arbitrate = 1'b0;
    check("sel_busy", 32'(arbBusy), 1);
    check("sel_valid", 32'(burst_valid), 0);
    tick();
    check("lat_valid", 32'(burst_valid), 0);
    check("lat_done", 32'(arbWriteTransactionsDone), 0);
    tick();
    for (int guard = 0; guard < 64 && !finished; guard++) begin
      w = model_winner();
      if (w < 0) begin
        check("done_pulse", 32'(arbWriteTransactionsDone), 1);
        check("done_valid", 32'(burst_valid), 0);
        tick();
        check("done_width", 32'(arbWriteTransactionsDone), 0);
        check("idle_busy", 32'(arbBusy), 0);
        finished = 1'b1;
      end else begin
        check_burst(w);
        bp = (force_bp >= 0) ? force_bp : int'($urandom_range(0, 2));
        for (int i = 0; i < bp; i++) begin
          if (arb_inject && nb == 0 && i == 1) arbitrate = 1'b1;
          tick();
          arbitrate = 1'b0;
          check_burst(w);
        end
        burst_ready = 1'b1;
        tick();
        burst_ready = 1'b0;
        m_rem[w] = m_rem[w] - ((m_rem[w] > MAXB) ? MAXB : m_rem[w]);
        if (m_rem[w] == 0) m_valid[w] = 1'b0;
        m_rr = w;
        grants.push_back(w);
        nb++;
        check("hs_valid_low", 32'(burst_valid), 0);
        dly = (done_dly >= 0) ? done_dly : int'($urandom_range(0, 3));
        for (int i = 0; i < dly; i++) begin
          if (hi_inject && nb == 1 && i == 0) do_sample(9, 15, 3);
          else if (rand_mid && $urandom_range(0, 3) == 0)
            do_sample(int'($urandom_range(0, 35)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 40)));
          else tick();
          check("wait_valid", 32'(burst_valid), 0);
        end
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        check("resp_valid0", 32'(burst_valid), 0);
        tick();
        check("resp_valid1", 32'(burst_valid), 0);
        tick();
      end
    end
    if (!finished) check("arb_guard", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    model_clear();
    do_reset();

    // 1: single channel split into 16/16/8 beats
    grants.delete();
    do_sample(3, 2, 40);
    run_arb(nb);
    check("t1_bursts", 32'(nb), 3);
    check("t1_grant2", 32'(grants[2]), 3);

    // 2: higher priority served first
    grants.delete();
    do_sample(1, 1, 16);
    do_sample(5, 7, 16);
    run_arb(nb);
    check("t2_bursts", 32'(nb), 2);
    check("t2_first", 32'(grants[0]), 5);
    check("t2_second", 32'(grants[1]), 1);

    // 3: round-robin between equal priorities from rr=0
    do_reset();
    grants.delete();
    do_sample(2, 3, 32);
    do_sample(4, 3, 32);
    run_arb(nb);
    check("t3_bursts", 32'(nb), 4);
    check("t3_g0", 32'(grants[0]), 2);
    check("t3_g1", 32'(grants[1]), 4);
    check("t3_g2", 32'(grants[2]), 2);
    check("t3_g3", 32'(grants[3]), 4);

    // 4: empty table, size-0 invalidation, out-of-range ID
    run_arb(nb);
    check("t4_empty", 32'(nb), 0);
    grants.delete();
    do_sample(7, 9, 20);
    do_sample(7, 9, 0);
    do_sample(6, 1, 4);
    run_arb(nb);
    check("t4_size0_bursts", 32'(nb), 1);
    check("t4_size0_grant", 32'(grants[0]), 6);
    do_sample(40, 5, 12);
    check("t4_iderr", 32'(arbIdError), 1);
    run_arb(nb);
    check("t4_id40_nowrite", 32'(nb), 0);

    // 5: backpressure with ignored arbitrate, high-priority mid-channel sample
    grants.delete();
    do_sample(0, 5, 20);
    do_sample(1, 5, 8);
    force_bp = 5; arb_inject = 1'b1; hi_inject = 1'b1;
    run_arb(nb);
    force_bp = 0; arb_inject = 1'b0; hi_inject = 1'b0;
    check("t5_bursts", 32'(nb), 4);
    check("t5_preempt", 32'(grants[1]), 9);
    tick();
    check("t5_idle", 32'(arbBusy), 0);

    // 6: asynchronous reset in WAIT_RESP
    do_sample(2, 1, 40);
    arbitrate = 1'b1;
    tick();
    arbitrate = 1'b0;
    tick();
    tick();
    check("t6_valid", 32'(burst_valid), 1);
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    tick();
    rst = 1'b0;
    tick();
    model_clear();
    run_arb(nb);
    check("t6_empty_after", 32'(nb), 0);

    // Randomized rounds against the model
    force_bp = -1; done_dly = -1; rand_mid = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int n = int'($urandom_range(1, 6));
      for (int s = 0; s < n; s++)
        do_sample(int'($urandom_range(0, 35)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 50)));
      run_arb(nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
